// File: rtl/morse_led_player.sv
// morse_led_player: LED code display and real-time playback engine.
//
// Static mode (mode=0, IDLE): shows a left-aligned code of 1..MAXW
// symbols on the LED bank. Unlit positions blink with a half-period
// of UNIT_CYCLES.
// Playback mode (mode=1): a start request plays the latched code.
// A dot is 1 unit, a dash is 3 units, and there is a 1-unit gap
// between symbols. The player drives the LED bank and a tone line.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   code   in   [MAXW-1:0] symbol bits (1 = dash), code[width-1] played first
//   width  in   [WW-1:0]   number of valid symbols, 1..MAXW
//   mode   in   0 = static display, 1 = playback
//   start  in   playback request
//   led    out  [LEDS-1:0] LED drive (registered)
//   tone   out  high during a mark (registered)
//   busy   out  playback in progress (registered)
//   done   out  one-cycle end-of-playback pulse (registered)
module morse_led_player #(
  parameter int MAXW        = 5,
  parameter int LEDS        = 8,
  parameter int UNIT_CYCLES = 33554432,
  parameter int WW          = $clog2(MAXW + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [MAXW-1:0] code,
  input  logic [WW-1:0]   width,
  input  logic            mode,
  input  logic            start,
  output logic [LEDS-1:0] led,
  output logic            tone,
  output logic            busy,
  output logic            done
);

  localparam int CW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(UNIT_CYCLES - 1);
  localparam logic [LEDS-1:0] LED_TOP  = {1'b1, {(LEDS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MARK = 2'd1, GAP = 2'd2, FIN = 2'd3} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            phase;
  logic [WW-1:0]   k;
  logic [WW-1:0]   lw;
  logic [1:0]      units;      // units elapsed in the current mark
  logic [MAXW-1:0] sym_sr;     // latched code, current symbol in the MSB
  logic [LEDS-1:0] sym_led;    // one-hot LED of the current symbol

  logic            tick;
  logic            width_ok;
  logic [MAXW-1:0] aligned;    // code shifted so symbol j sits at bit MAXW-1-j
  logic [LEDS-1:0] static_led;
  logic [1:0]      mark_last;  // index of the final unit of this mark

  // Decode of timer wrap, width validity, alignment and static pattern.
  always_comb begin
    tick       = (cnt == CNT_LAST);
    width_ok   = (width != {WW{1'b0}}) && (width <= WW'(MAXW));
    aligned    = code << (WW'(MAXW) - width);
    mark_last  = sym_sr[MAXW-1] ? 2'd2 : 2'd0;
    static_led = {LEDS{1'b0}};
    if (width_ok) begin
      for (int j = 0; j < MAXW; j++) begin
        if (WW'(j) < width) begin
          static_led[LEDS-1-j] = aligned[MAXW-1-j] | phase;
        end else begin
          static_led[LEDS-1-j] = 1'b0;
        end
      end
    end else begin
      static_led = {LEDS{1'b0}};
    end
  end

  // Playback FSM, unit timer, blink phase and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= {CW{1'b0}};
      phase   <= 1'b0;
      k       <= {WW{1'b0}};
      lw      <= {WW{1'b0}};
      units   <= 2'd0;
      sym_sr  <= {MAXW{1'b0}};
      sym_led <= {LEDS{1'b0}};
      led     <= {LEDS{1'b0}};
      tone    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      cnt  <= tick ? {CW{1'b0}} : cnt + CW'(1);
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) phase <= ~phase;
          if (mode && width_ok && start) begin
            // Restart the timer so the first mark is a full unit long.
            cnt     <= {CW{1'b0}};
            sym_sr  <= aligned;
            lw      <= width;
            k       <= {WW{1'b0}};
            units   <= 2'd0;
            sym_led <= LED_TOP;
            led     <= LED_TOP;
            tone    <= 1'b1;
            busy    <= 1'b1;
            state   <= MARK;
          end else begin
            led  <= mode ? {LEDS{1'b0}} : static_led;
            tone <= 1'b0;
            busy <= 1'b0;
          end
        end
        MARK: begin
          if (tick) begin
            if (units == mark_last) begin
              units <= 2'd0;
              tone  <= 1'b0;
              led   <= {LEDS{1'b0}};
              if (k == lw - WW'(1)) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FIN;
              end else begin
                state <= GAP;
              end
            end else begin
              units <= units + 2'd1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            k       <= k + WW'(1);
            sym_sr  <= sym_sr << 1;
            sym_led <= sym_led >> 1;
            led     <= sym_led >> 1;
            tone    <= 1'b1;
            state   <= MARK;
          end
        end
        FIN: begin
          // One cycle here keeps a held start from re-triggering on the done edge.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          led   <= {LEDS{1'b0}};
          tone  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_led_player.sv
// Self-checking bench for morse_led_player with UNIT_CYCLES=4.
module tb_morse_led_player;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] code;
  logic [2:0] width;
  logic       mode;
  logic       start;
  logic [7:0] led;
  logic       tone;
  logic       busy;
  logic       done;

  int n_total = 0;
  int n_pass  = 0;

  // Trace of {tone, busy, done, led} after each captured edge.
  logic [10:0] tr [0:99];

  morse_led_player #(.MAXW(5), .LEDS(8), .UNIT_CYCLES(U)) dut (
    .clk(clk), .rst(rst), .code(code), .width(width), .mode(mode),
    .start(start), .led(led), .tone(tone), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [2:0] width;
    logic [4:0] code;
    logic [7:0] led;
  } vec_t;

  vec_t tbl [0:17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start is set by the caller; it is dropped after the first edge unless held.
  task automatic capture(input int n, input bit hold, input bit perturb);
    for (int i = 0; i < n; i++) begin
      step();
      tr[i] = {tone, busy, done, led};
      if (!hold) start = 1'b0;
      if (perturb && i == 2) begin
        code = 5'b00000;
        mode = 1'b0;
      end
    end
  endtask

  // Build the expected waveform from the symbol list and compare the trace.
  task automatic check_model(input string name, input int w, input logic [4:0] c, input int busy_exp);
    logic [10:0] exp_tr [0:99];
    int idx;
    int len;
    int nb;
    idx = 0;
    for (int s = 0; s < w; s++) begin
      len = c[w-1-s] ? 3 * U : U;
      for (int t = 0; t < len; t++) begin
        exp_tr[idx] = {1'b1, 1'b1, 1'b0, 8'h80 >> s};
        idx++;
      end
      if (s < w - 1) begin
        for (int t = 0; t < U; t++) begin
          exp_tr[idx] = {1'b0, 1'b1, 1'b0, 8'h00};
          idx++;
        end
      end
    end
    exp_tr[idx] = {1'b0, 1'b0, 1'b1, 8'h00};
    for (int i = 0; i <= idx; i++) begin
      chk($sformatf("%s cyc%0d", name, i), 32'(tr[i]), 32'(exp_tr[i]));
    end
    nb = 0;
    for (int i = 0; i <= idx; i++) if (tr[i][9]) nb++;
    chk({name, " busy_len"}, 32'(nb), 32'(busy_exp));
  endtask

  task automatic wait_idle(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    chk({name, " done_seen"}, 32'(seen), 32'd1);
    step();
    step();
  endtask

  initial begin
    tbl[0]  = '{1'b0, 3'd3, 5'b00101, 8'hA0};
    tbl[1]  = '{1'b0, 3'd3, 5'b00101, 8'hA0};
    tbl[2]  = '{1'b0, 3'd3, 5'b00101, 8'hA0};
    tbl[3]  = '{1'b0, 3'd3, 5'b00101, 8'hA0};
    tbl[4]  = '{1'b0, 3'd3, 5'b00101, 8'hE0};
    tbl[5]  = '{1'b0, 3'd3, 5'b00101, 8'hE0};
    tbl[6]  = '{1'b0, 3'd3, 5'b00101, 8'hE0};
    tbl[7]  = '{1'b0, 3'd3, 5'b00101, 8'hE0};
    tbl[8]  = '{1'b0, 3'd0, 5'b00101, 8'h00};
    tbl[9]  = '{1'b0, 3'd6, 5'b00101, 8'h00};
    tbl[10] = '{1'b0, 3'd3, 5'b00101, 8'hA0};
    tbl[11] = '{1'b0, 3'd1, 5'b00000, 8'h00};
    tbl[12] = '{1'b0, 3'd1, 5'b00000, 8'h80};
    tbl[13] = '{1'b0, 3'd5, 5'b10110, 8'hF8};
    tbl[14] = '{1'b1, 3'd5, 5'b10110, 8'h00};
    tbl[15] = '{1'b0, 3'd5, 5'b10110, 8'hF8};
    tbl[16] = '{1'b0, 3'd5, 5'b10110, 8'hB0};
    tbl[17] = '{1'b0, 3'd7, 5'b10110, 8'h00};

    // Reset state.
    rst = 1'b1; mode = 1'b0; width = 3'd3; code = 5'b00101; start = 1'b0;
    step();
    step();
    chk("reset outputs", {21'd0, tone, busy, done, led}, 32'd0);
    rst = 1'b0;

    // Static display vectors, one edge each, starting from phase=0, cnt=0.
    for (int i = 0; i < 18; i++) begin
      mode = tbl[i].mode; width = tbl[i].width; code = tbl[i].code;
      step();
      chk($sformatf("static led v%0d", i), 32'(led), 32'(tbl[i].led));
      chk($sformatf("static ctl v%0d", i), {29'd0, tone, busy, done}, 32'd0);
    end

    // Playback: two dots.
    mode = 1'b1; width = 3'd2; code = 5'b00000; start = 1'b1;
    capture(16, 1'b0, 1'b0);
    check_model("dots", 2, 5'b00000, 12);
    chk("dots tone E+3", 32'(tr[3][10]), 32'd1);
    chk("dots tone E+4", 32'(tr[4][10]), 32'd0);
    chk("dots done E+13", 32'(tr[13][8]), 32'd0);
    step();

    // Playback: dash then dot.
    width = 3'd2; code = 5'b00010; start = 1'b1;
    capture(24, 1'b0, 1'b0);
    check_model("dashdot", 2, 5'b00010, 20);
    step();

    // Start held high: re-accepted in the IDLE cycle after FIN.
    width = 3'd1; code = 5'b00001; start = 1'b1;
    capture(16, 1'b1, 1'b0);
    check_model("held", 1, 5'b00001, 12);
    chk("held busy D+1", 32'(tr[13][9]), 32'd0);
    chk("held done D+1", 32'(tr[13][8]), 32'd0);
    chk("held busy D+2", 32'(tr[14][9]), 32'd1);
    start = 1'b0;
    wait_idle("held second run");

    // Invalid start requests never raise busy.
    begin
      bit any_busy;
      any_busy = 1'b0;
      width = 3'd0; mode = 1'b1; start = 1'b1;
      for (int i = 0; i < 10; i++) begin step(); if (busy) any_busy = 1'b1; end
      chk("start width0 busy", 32'(any_busy), 32'd0);
      width = 3'd2; mode = 1'b0;
      for (int i = 0; i < 10; i++) begin step(); if (busy) any_busy = 1'b1; end
      chk("start mode0 busy", 32'(any_busy), 32'd0);
      start = 1'b0;
      step();
    end

    // Inputs change mid-playback: five dashes still play.
    mode = 1'b1; width = 3'd5; code = 5'b11111; start = 1'b1;
    capture(80, 1'b0, 1'b1);
    check_model("midchange", 5, 5'b11111, 76);
    mode = 1'b1;
    step();
    step();

    // Reset during a dash aborts with no done pulse.
    width = 3'd1; code = 5'b00001; start = 1'b1;
    step();
    start = 1'b0;
    chk("pre-reset busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    chk("abort outputs", {21'd0, tone, busy, done, led}, 32'd0);
    step();
    rst = 1'b0;
    begin
      bit any_done;
      any_done = 1'b0;
      for (int i = 0; i < 20; i++) begin step(); if (done || busy) any_done = 1'b1; end
      chk("no done after abort", 32'(any_done), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/morse_led_player.md
# morse_led_player

Parametrised LED code display and playback engine for the board's LED bank, succeeding the fixed 5-symbol, 8-LED static display. In static mode it shows a left-aligned code of 1..MAXW symbols with the unlit positions blinking. In playback mode it sequences the code in real time (dot = 1 unit, dash = 3 units, 1-unit inter-symbol gap) under a start/busy/done handshake, driving the LED bank and a tone line for the buzzer.

## Interface
- MAXW, 5, maximum code length in symbols; MAXW <= LEDS.
- LEDS, 8, width of the LED bank.
- UNIT_CYCLES, 33554432, clk cycles per time unit (>= 2); also the half-period of the static blink.
- WW, $clog2(MAXW+1), width of the `width` port (derived).
- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-high.
- code  in  MAXW  symbol bits; 1 = dash, 0 = dot; code[width-1] is the leftmost and first-played symbol.
- width  in  WW  number of valid symbols; valid range 1..MAXW.
- mode  in  1  0 = static display, 1 = playback.
- start  in  1  playback request, sampled on every clk edge.
- led  out  LEDS  LED drive, registered.
- tone  out  1  high during a mark, registered.
- busy  out  1  playback in progress, registered.
- done  out  1  one-cycle pulse at the end of playback, registered.

## Operation
- Unit timer: counter 0..UNIT_CYCLES-1 with a tick on wrap.
  - It free-runs in IDLE, and a `phase` bit toggles on every tick.
  - It is cleared to 0 when start is accepted.
- FSM states: IDLE, MARK, GAP, FIN.
- IDLE, mode=0 (static display):
  - For w = width in 1..MAXW: led[LEDS-1-j] = code[w-1-j] | phase for j = 0..w-1.
  - All other LEDs are 0.
  - width = 0 or width > MAXW drives all LEDs to 0.
  - tone stays 0.
- IDLE, mode=1: led = 0 and tone = 0.
- Start acceptance:
  - Start is accepted only in IDLE with mode=1 and 1 <= width <= MAXW.
  - On acceptance, code and width are latched, the symbol index k is set to 0, and the FSM moves to MARK.
  - Start in any other state or condition is ignored. No error is flagged.
- MARK:
  - Drives tone=1 and busy=1.
  - Lights only led[LEDS-1-k]; all other LEDs are 0.
  - Symbol bit is latched_code[w-1-k].
  - Lasts 1 unit for a dot or 3 units for a dash.
  - Then moves to GAP if k < w-1, or to FIN if k = w-1.
- GAP:
  - Drives tone=0, led=0, busy=1.
  - Lasts 1 unit, then k increments and the FSM returns to MARK.
- FIN:
  - Lasts one cycle with done=1, busy=0, led=0, tone=0.
  - Then returns to IDLE.
- Changes to mode, code or width during playback do not affect the sequence in progress.

## Timing
- Reset state: state=IDLE, counter=0, phase=0, k=0, led=0, tone=0, busy=0, done=0.
- rst mid-playback aborts immediately. No done pulse is produced.
- Start latency:
  - Start sampled high at edge E.
  - From E, busy=1, tone=1 and the first symbol's LED are visible.
- Durations, all exact:
  - Dot mark = UNIT_CYCLES cycles.
  - Dash mark = 3*UNIT_CYCLES cycles.
  - Gap = UNIT_CYCLES cycles.
- busy high-time = UNIT_CYCLES * (sum of mark units + w-1).
- done rises on the edge where busy falls and stays high for exactly 1 cycle.
- Start held high continuously:
  - It is not re-accepted in FIN.
  - It is re-accepted in the IDLE cycle that follows FIN.
  - The next playback's busy therefore rises 2 cycles after done rises.
- Static-mode outputs follow code, width and mode combinationally into the registered led, so they update 1 cycle after an input change.
- phase period = 2*UNIT_CYCLES.
- A mode change to 0 in IDLE yields the static display from the next cycle, with the blink continuing from the current phase.

## Test plan
- Reset: with UNIT_CYCLES=4, assert rst for 2 cycles during a dash -> next cycle led=0, tone=0, busy=0, done=0; no done afterwards.
- Static mode: mode=0, width=3, code=3'b101 -> led=8'b1010_0000 while phase=0, led=8'b1110_0000 while phase=1, toggling every 4 cycles; width=0 and width=6 -> led=0.
- Playback, all dots: UNIT_CYCLES=4, mode=1, width=2, code=2'b00, start pulse at E:
  - tone high E..E+3, low E+4..E+7, high E+8..E+11.
  - led=8'h80, then 0, then 8'h40.
  - busy high 12 cycles; done=1 at E+12 only.
- Playback, dash/dot: width=2, code=2'b10 -> first mark 12 cycles on led[7], gap 4, second mark 4 cycles on led[6]; busy high 20 cycles.
- Handshake: start held high for the entire run with width=1, code=1 -> busy 12 cycles, done 1 cycle, busy re-rises 2 cycles after done; start with width=0 or mode=0 -> busy never rises.
- Input change mid-playback: width=5, code=5'b11111, change code to 0 and mode to 0 after 3 cycles -> the sequence still plays 5 dashes (busy = 4*(15+4) = 76 cycles), then done.
